wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile_pkg.sv | 18 +
 rtl/wb_regfile_reg32.sv | 32 +++
 rtl/wb_regfile.sv | 67 ++++++
 tb/tb_wb_regfile.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared widths, types and write-commit rule for the MEM/WB register file.
package wb_regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     data_t;

  localparam reg_addr_t ZERO_REG = '0;

  // A write commits only outside reset and never to the hard-wired zero register.
  function automatic logic write_commit(input logic rst, input logic reg_write, input reg_addr_t wn);
    return !rst && reg_write && (wn != ZERO_REG);
  endfunction

endpackage

// File: rtl/wb_regfile_reg32.sv
// Single 32-bit storage register with synchronous clear and load enable.
module reg32
  import wb_regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en_reg,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out
);

  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (en_reg) begin
      data_d = d_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign d_out = data_q;

endmodule

// File: rtl/wb_regfile.sv
// 32x32 register file with write-back data mux, write-through bypass and a
// registered commit flag. Register 0 is hard-wired to zero.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWrite,
  input  logic                  MemtoReg,
  input  logic [REG_ADDR_W-1:0] wn,
  input  logic [DATA_W-1:0]     rd,
  input  logic [DATA_W-1:0]     total_alu,
  input  logic [REG_ADDR_W-1:0] rn1,
  input  logic [REG_ADDR_W-1:0] rn2,
  output logic [DATA_W-1:0]     rd1,
  output logic [DATA_W-1:0]     rd2,
  output logic [DATA_W-1:0]     wd,
  output logic                  wb_valid
);

  logic              wr_commit;
  logic              wb_valid_d;
  logic              wb_valid_q;
  logic [DATA_W-1:0] reg_data [NUM_REGS];

  assign wd        = MemtoReg ? rd : total_alu;
  assign wr_commit = write_commit(rst, RegWrite, wn);

  assign reg_data[0] = '0;

  // Reset priority over the enable is handled inside each reg32.
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    logic en_reg;
    assign en_reg = RegWrite && (wn == REG_ADDR_W'(i));
    reg32 u_reg32 (
      .clk   (clk),
      .rst   (rst),
      .en_reg(en_reg),
      .d_in  (wd),
      .d_out (reg_data[i])
    );
  end

  always_comb begin
    rd1 = reg_data[rn1];
    rd2 = reg_data[rn2];
    if (wr_commit && (wn == rn1)) begin
      rd1 = wd;
    end
    if (wr_commit && (wn == rn2)) begin
      rd2 = wd;
    end
  end

  assign wb_valid_d = wr_commit;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
    end else begin
      wb_valid_q <= wb_valid_d;
    end
  end

  assign wb_valid = wb_valid_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard-driven bench for wb_regfile: directed scenarios plus a random back-to-back run.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite;
  logic        MemtoReg;
  logic [4:0]  wn;
  logic [31:0] rd;
  logic [31:0] total_alu;
  logic [4:0]  rn1;
  logic [4:0]  rn2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] wd;
  logic        wb_valid;

  logic [31:0] model [32];
  logic [31:0] exp_q [$];
  logic [31:0] e;
  int          n_checks = 0;
  int          n_fail   = 0;

  wb_regfile dut (
    .clk      (clk),
    .rst      (rst),
    .RegWrite (RegWrite),
    .MemtoReg (MemtoReg),
    .wn       (wn),
    .rd       (rd),
    .total_alu(total_alu),
    .rn1      (rn1),
    .rn2      (rn2),
    .rd1      (rd1),
    .rd2      (rd2),
    .wd       (wd),
    .wb_valid (wb_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    rst = 1'b1; RegWrite = 1'b0; MemtoReg = 1'b0; wn = '0; rd = '0; total_alu = '0;
    rn1 = '0; rn2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); n_checks++;
    if ({31'h0, wb_valid} !== e) begin
      n_fail++; $display("FAIL reset_wb_valid: got %0h expected %0h", wb_valid, e);
    end
    for (int i = 0; i < 32; i++) begin
      rn1 = 5'(i); rn2 = 5'(31 - i);
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      #1;
      e = exp_q.pop_front(); n_checks++;
      if (rd1 !== e) begin
        n_fail++; $display("FAIL reset_rd1[%0d]: got %h expected %h", i, rd1, e);
      end
      e = exp_q.pop_front(); n_checks++;
      if (rd2 !== e) begin
        n_fail++; $display("FAIL reset_rd2[%0d]: got %h expected %h", 31 - i, rd2, e);
      end
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    RegWrite = 1'b1; MemtoReg = 1'b0; wn = 5'd5; total_alu = 32'hDEADBEEF; rd = 32'h0BAD0BAD;
    rn1 = 5'd1; rn2 = 5'd6;
    exp_q.push_back(32'hDEADBEEF); exp_q.push_back(model[6]);
    #1;
    e = exp_q.pop_front(); n_checks++;
    if (wd !== e) begin
      n_fail++; $display("FAIL basic_wd: got %h expected %h", wd, e);
    end
    e = exp_q.pop_front(); n_checks++;
    if (rd2 !== e) begin
      n_fail++; $display("FAIL basic_independent_rd2: got %h expected %h", rd2, e);
    end
    @(posedge clk);
    model[5] = 32'hDEADBEEF;
    #1;
    RegWrite = 1'b0; rn1 = 5'd5;
    exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'h1);
    #1;
    e = exp_q.pop_front(); n_checks++;
    if (rd1 !== e) begin
      n_fail++; $display("FAIL basic_rd1: got %h expected %h", rd1, e);
    end
    e = exp_q.pop_front(); n_checks++;
    if ({31'h0, wb_valid} !== e) begin
      n_fail++; $display("FAIL basic_wb_valid: got %0h expected %0h", wb_valid, e);
    end
  endtask

  task automatic test_mux_bypass();
    @(negedge clk);
    RegWrite = 1'b1; MemtoReg = 1'b1; rd = 32'h12345678; total_alu = 32'hFFFFFFFF;
    wn = 5'd7; rn1 = 5'd7; rn2 = 5'd7;
    exp_q.push_back(32'h12345678); exp_q.push_back(32'h12345678); exp_q.push_back(32'h12345678);
    #1;
    e = exp_q.pop_front(); n_checks++;
    if (wd !== e) begin
      n_fail++; $display("FAIL mux_wd: got %h expected %h", wd, e);
    end
    e = exp_q.pop_front(); n_checks++;
    if (rd1 !== e) begin
      n_fail++; $display("FAIL bypass_rd1: got %h expected %h", rd1, e);
    end
    e = exp_q.pop_front(); n_checks++;
    if (rd2 !== e) begin
      n_fail++; $display("FAIL bypass_rd2: got %h expected %h", rd2, e);
    end
    @(posedge clk);
    model[7] = 32'h12345678;
    #1;
    RegWrite = 1'b0;
    exp_q.push_back(32'h12345678);
    #1;
    e = exp_q.pop_front(); n_checks++;
    if (rd1 !== e) begin
      n_fail++; $display("FAIL mux_stored_rd1: got %h expected %h", rd1, e);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    RegWrite = 1'b1; MemtoReg = 1'b0; wn = 5'd0; total_alu = 32'hAAAA5555;
    rn1 = 5'd0; rn2 = 5'd0;
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); n_checks++;
    if (rd1 !== e) begin
      n_fail++; $display("FAIL zero_rd1_before: got %h expected %h", rd1, e);
    end
    @(posedge clk);
    #1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); n_checks++;
    if (rd1 !== e) begin
      n_fail++; $display("FAIL zero_rd1_after: got %h expected %h", rd1, e);
    end
    e = exp_q.pop_front(); n_checks++;
    if ({31'h0, wb_valid} !== e) begin
      n_fail++; $display("FAIL zero_wb_valid: got %0h expected %0h", wb_valid, e);
    end
    RegWrite = 1'b0;
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    RegWrite = 1'b1; MemtoReg = 1'b0; wn = 5'd9; total_alu = 32'h1;
    @(posedge clk);
    model[9] = 32'h1;
    @(negedge clk);
    rst = 1'b1; RegWrite = 1'b1; wn = 5'd9; total_alu = 32'h77; rn1 = 5'd9; rn2 = 5'd5;
    exp_q.push_back(32'h1);
    #1;
    e = exp_q.pop_front(); n_checks++;
    if (rd1 !== e) begin
      n_fail++; $display("FAIL rstprio_no_bypass: got %h expected %h", rd1, e);
    end
    @(posedge clk);
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    #1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); n_checks++;
    if (rd1 !== e) begin
      n_fail++; $display("FAIL rstprio_reg9: got %h expected %h", rd1, e);
    end
    e = exp_q.pop_front(); n_checks++;
    if (rd2 !== e) begin
      n_fail++; $display("FAIL rstprio_reg5_cleared: got %h expected %h", rd2, e);
    end
    e = exp_q.pop_front(); n_checks++;
    if ({31'h0, wb_valid} !== e) begin
      n_fail++; $display("FAIL rstprio_wb_valid: got %0h expected %0h", wb_valid, e);
    end
    rst = 1'b0; RegWrite = 1'b0;
    // First edge after reset release must accept a write.
    @(negedge clk);
    RegWrite = 1'b1; wn = 5'd12; total_alu = 32'h0C0FFEE0; rn1 = 5'd12;
    @(posedge clk);
    model[12] = 32'h0C0FFEE0;
    #1;
    RegWrite = 1'b0;
    exp_q.push_back(32'h0C0FFEE0);
    #1;
    e = exp_q.pop_front(); n_checks++;
    if (rd1 !== e) begin
      n_fail++; $display("FAIL first_write_after_rst: got %h expected %h", rd1, e);
    end
  endtask

  task automatic test_disabled_write();
    @(negedge clk);
    RegWrite = 1'b1; MemtoReg = 1'b0; wn = 5'd3; total_alu = 32'h0000CAFE;
    @(posedge clk);
    model[3] = 32'h0000CAFE;
    @(negedge clk);
    RegWrite = 1'b0; wn = 5'd3; total_alu = 32'h55; rn1 = 5'd3;
    exp_q.push_back(32'h0000CAFE);
    #1;
    e = exp_q.pop_front(); n_checks++;
    if (rd1 !== e) begin
      n_fail++; $display("FAIL disabled_no_bypass: got %h expected %h", rd1, e);
    end
    @(posedge clk);
    #1;
    exp_q.push_back(32'h0000CAFE); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); n_checks++;
    if (rd1 !== e) begin
      n_fail++; $display("FAIL disabled_unchanged: got %h expected %h", rd1, e);
    end
    e = exp_q.pop_front(); n_checks++;
    if ({31'h0, wb_valid} !== e) begin
      n_fail++; $display("FAIL disabled_wb_valid: got %0h expected %0h", wb_valid, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_wd;
    logic        commit;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      RegWrite  = ($urandom_range(0, 3) != 0);
      MemtoReg  = 1'($urandom_range(0, 1));
      wn        = 5'($urandom_range(0, 7));
      rd        = $urandom;
      total_alu = $urandom;
      rn1       = 5'($urandom_range(0, 7));
      rn2       = ($urandom_range(0, 3) == 0) ? rn1 : 5'($urandom_range(0, 7));
      exp_wd    = MemtoReg ? rd : total_alu;
      commit    = RegWrite && (wn != 5'd0);
      exp_q.push_back(exp_wd);
      exp_q.push_back((commit && wn == rn1) ? exp_wd : model[rn1]);
      exp_q.push_back((commit && wn == rn2) ? exp_wd : model[rn2]);
      #1;
      e = exp_q.pop_front(); n_checks++;
      if (wd !== e) begin
        n_fail++; $display("FAIL b2b_wd[%0d]: got %h expected %h", n, wd, e);
      end
      e = exp_q.pop_front(); n_checks++;
      if (rd1 !== e) begin
        n_fail++; $display("FAIL b2b_rd1[%0d] rn1=%0d: got %h expected %h", n, rn1, rd1, e);
      end
      e = exp_q.pop_front(); n_checks++;
      if (rd2 !== e) begin
        n_fail++; $display("FAIL b2b_rd2[%0d] rn2=%0d: got %h expected %h", n, rn2, rd2, e);
      end
      @(posedge clk);
      if (commit) model[wn] = exp_wd;
      exp_q.push_back({31'h0, commit});
      #1;
      e = exp_q.pop_front(); n_checks++;
      if ({31'h0, wb_valid} !== e) begin
        n_fail++; $display("FAIL b2b_wb_valid[%0d]: got %0h expected %0h", n, wb_valid, e);
      end
    end
    @(negedge clk);
    RegWrite = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mux_bypass();
    test_zero_reg();
    test_reset_priority();
    test_disabled_write();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
